// File: rtl/freq_gate_pkg.sv
// Shared types and default sizing for the gated frequency-measurement engine.
// Defaults describe a 10 ms gate on the 48 MHz HSOSC with a 10-bit result.
package freq_gate_pkg;

    typedef enum logic {
        FG_IDLE  = 1'b0,
        FG_COUNT = 1'b1
    } fg_state_t;

    localparam int FG_CLK_HZ        = 48_000_000;
    localparam int FG_GATE_HZ       = 100;
    localparam int FG_WINDOW_CYCLES = FG_CLK_HZ / FG_GATE_HZ;
    localparam int FG_TIMER_W       = 26;
    localparam int FG_CNT_W         = 10;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin plus a history flop.
// o_fall is a one-cycle pulse when the synchronised level goes 1 -> 0.
module sync_edge_detect (
    input  logic clk,
    input  logic srst,
    input  logic i_async,
    output logic o_level,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_level = r_sync2;
    assign o_fall  = r_prev & ~r_sync2;

endmodule

// File: rtl/freq_gate_counter.sv
// Free-running gated edge counter: back-to-back windows of WINDOW_CYCLES clocks,
// one saturated falling-edge count per window delivered through a valid/ready register.
module freq_gate_counter
    import freq_gate_pkg::*;
#(
    parameter int WINDOW_CYCLES = FG_WINDOW_CYCLES,
    parameter int TIMER_W       = FG_TIMER_W,
    parameter int CNT_W         = FG_CNT_W
) (
    input  logic             int_osc,
    input  logic             reset,
    input  logic             square,
    input  logic             enable,
    output logic             collecting,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overrun
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    fg_state_t          r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_win_ovf;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_count_valid;
    logic               r_overrun;

    logic               w_fall;
    logic               w_unused_level;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_ovf_next;
    logic               w_terminal;
    logic               w_xfer;
    logic               w_load;

    sync_edge_detect u_square_sync (
        .clk     (int_osc),
        .srst    (reset),
        .i_async (square),
        .o_level (w_unused_level),
        .o_fall  (w_fall)
    );

    // Count value including this cycle's edge, so a terminal-cycle edge lands in the closing window.
    always_comb begin
        w_cnt_next = r_edge_cnt;
        if (w_fall && (r_edge_cnt != CNT_MAX)) begin
            w_cnt_next = r_edge_cnt + CNT_W'(1);
        end
    end

    assign w_ovf_next = r_win_ovf | (w_cnt_next == CNT_MAX);
    assign w_terminal = (r_state == FG_COUNT) && enable && (r_timer == TIMER_LAST);
    assign w_xfer     = r_count_valid && count_ready;
    assign w_load     = w_terminal && (!r_count_valid || w_xfer);

    always_ff @(posedge int_osc) begin
        if (reset) begin
            r_state    <= FG_IDLE;
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
        end else begin
            case (r_state)
                FG_IDLE: begin
                    r_timer    <= '0;
                    r_edge_cnt <= '0;
                    r_win_ovf  <= 1'b0;
                    if (enable) begin
                        r_state <= FG_COUNT;
                    end
                end
                FG_COUNT: begin
                    if (!enable) begin
                        r_state    <= FG_IDLE;
                        r_timer    <= '0;
                        r_edge_cnt <= '0;
                        r_win_ovf  <= 1'b0;
                    end else if (w_terminal) begin
                        r_timer    <= '0;
                        r_edge_cnt <= '0;
                        r_win_ovf  <= 1'b0;
                    end else begin
                        r_timer    <= r_timer + TIMER_W'(1);
                        r_edge_cnt <= w_cnt_next;
                        r_win_ovf  <= w_ovf_next;
                    end
                end
                default: begin
                    r_state <= FG_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge int_osc) begin
        if (reset) begin
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_count_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_load) begin
                r_count       <= w_cnt_next;
                r_overflow    <= w_ovf_next;
                r_count_valid <= 1'b1;
            end else if (w_xfer) begin
                r_count_valid <= 1'b0;
            end
            // A finished window with nowhere to go is lost; remember that until reset.
            if (w_terminal && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign collecting  = (r_state == FG_COUNT);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign count_valid = r_count_valid;
    assign overrun     = r_overrun;

endmodule
